// File: rtl/time_set_input_if.sv
// Signal bundle for the time-entry block: raw buttons and current time in, edited time and status out.
interface time_set_input_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] time_hours;
    logic [7:0] time_minutes;
    logic [7:0] set_hours;
    logic [7:0] set_minutes;
    logic       load;
    logic       editing;
    logic [1:0] field_sel;

    modport master (
        output btn_mode, btn_up, btn_down, time_hours, time_minutes,
        input  set_hours, set_minutes, load, editing, field_sel
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, time_hours, time_minutes,
        output set_hours, set_minutes, load, editing, field_sel
    );
endinterface

// File: rtl/time_set_input.sv
// Debounced three-button BCD hours/minutes editor with a one-cycle commit strobe.
// Optional hold-to-repeat on up/down is enabled by defining TIME_SET_AUTO_REPEAT_EN.
module time_set_input #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_RATE     = 10_000_000
) (
    input logic            clk,
    input logic            rst_n,
    time_set_input_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("time_set_input: timing parameters must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, EDIT_H, EDIT_M, COMMIT} state_t;

    state_t        state, state_next;
    logic [7:0]    hours_q, hours_next, minutes_q, minutes_next;
    logic [2:0]    raw, sync1, sync2, deb, deb_d, press, rep, ev;
    logic [DW-1:0] db_cnt [3];
    logic          mode, up, down;

    // Bit 0 = mode, bit 1 = up, bit 2 = down throughout.
    assign raw   = {bus.btn_down, bus.btn_up, bus.btn_mode};
    assign press = deb & ~deb_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)         return 8'h00;
        if (v[3:0] == 4'h9)   return {v[7:4] + 4'h1, 4'h0};
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00)       return max;
        if (v[3:0] == 4'h0)   return {v[7:4] - 4'h1, 4'h9};
        return {v[7:4], v[3:0] - 4'h1};
    endfunction

    // For well-formed BCD the byte ordering matches the decimal ordering.
    function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max);
        if (v[7:4] > 4'h9 || v[3:0] > 4'h9 || v > max) return 8'h00;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            ev    <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            ev    <= press | rep;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rpt_cnt [2];
    logic [1:0]    rpt_first;
    logic          rpt_active;

    // rpt_cnt holds cycles since the last up/down event; zero means not armed.
    assign rpt_active = (state == EDIT_H || state == EDIT_M) && (state_next == state);

    always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++) begin
            rep[i+1] = rpt_active && deb[i+1] && !press[i+1] &&
                       (rpt_cnt[i] == (rpt_first[i] ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_first <= '1;
            for (int i = 0; i < 2; i++) rpt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!rpt_active || !deb[i+1]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_first[i] <= 1'b1;
                end else if (press[i+1]) begin
                    rpt_cnt[i]   <= RW'(1);
                    rpt_first[i] <= 1'b1;
                end else if (rep[i+1]) begin
                    rpt_cnt[i]   <= RW'(1);
                    rpt_first[i] <= 1'b0;
                end else if (rpt_cnt[i] != '0) begin
                    rpt_cnt[i]   <= rpt_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign rep = '0;
`endif

    assign mode = ev[0];
    assign up   = ev[1] & ~ev[2];
    assign down = ev[2] & ~ev[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hours_q   <= 8'h00;
            minutes_q <= 8'h00;
        end else begin
            state     <= state_next;
            hours_q   <= hours_next;
            minutes_q <= minutes_next;
        end
    end

    // Mode takes priority so a simultaneous up/down never alters the value.
    always_comb begin
        state_next   = state;
        hours_next   = hours_q;
        minutes_next = minutes_q;
        case (state)
            IDLE: if (mode) begin
                hours_next   = bcd_sanitize(bus.time_hours, 8'h23);
                minutes_next = bcd_sanitize(bus.time_minutes, 8'h59);
                state_next   = EDIT_H;
            end
            EDIT_H: begin
                if (mode)      state_next = EDIT_M;
                else if (up)   hours_next = bcd_inc(hours_q, 8'h23);
                else if (down) hours_next = bcd_dec(hours_q, 8'h23);
            end
            EDIT_M: begin
                if (mode)      state_next   = COMMIT;
                else if (up)   minutes_next = bcd_inc(minutes_q, 8'h59);
                else if (down) minutes_next = bcd_dec(minutes_q, 8'h59);
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.set_hours   = hours_q;
    assign bus.set_minutes = minutes_q;
    assign bus.load        = (state == COMMIT);
    assign bus.editing     = (state == EDIT_H) || (state == EDIT_M);
    assign bus.field_sel   = (state == EDIT_H) ? 2'd1 : (state == EDIT_M) ? 2'd2 : 2'd0;
endmodule

// File: tb/tb_time_set_input.sv
// Self-checking bench for time_set_input: vector table, hand-written corner sequences and a randomized run against a decimal model.
module tb_time_set_input;
    localparam int DEB   = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    time_set_input_if bus();

    time_set_input #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_RATE    (RRATE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0] th, tm;
        int         up_h, dn_h, up_m, dn_m;
        logic [7:0] cap_h, cap_m, exp_h, exp_m;
    } vec_t;

    vec_t       vecs [11];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         load_cnt = 0;
    logic [7:0] load_h   = 8'h00;
    logic [7:0] load_m   = 8'h00;

    always @(negedge clk) begin
        if (bus.load === 1'b1) begin
            load_cnt++;
            load_h = bus.set_hours;
            load_m = bus.set_minutes;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic setBtn(input int which, input logic v);
        case (which)
            0:       bus.btn_mode = v;
            1:       bus.btn_up   = v;
            default: bus.btn_down = v;
        endcase
    endtask

    // Hold a button for `hold` sampled edges, then wait out the release debounce.
    task automatic applyStimulus(input int which, input int hold);
        @(negedge clk);
        setBtn(which, 1'b1);
        repeat (hold) @(negedge clk);
        setBtn(which, 1'b0);
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic pressN(input int which, input int n);
        for (int i = 0; i < n; i++) applyStimulus(which, DEB + 1);
    endtask

    function automatic int decode(input logic [7:0] b, input int maxv);
        int hi = int'(b[7:4]);
        int lo = int'(b[3:0]);
        if (hi > 9 || lo > 9) return 0;
        if (hi * 10 + lo > maxv) return 0;
        return hi * 10 + lo;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int         lc;
        int         mstate, mh, mm, exp_loads;
        logic [7:0] exp_rep;

        bus.btn_mode     = 1'b0;
        bus.btn_up       = 1'b0;
        bus.btn_down     = 1'b0;
        bus.time_hours   = 8'h00;
        bus.time_minutes = 8'h00;

        vecs[0]  = '{8'h12, 8'h34, 0, 0, 0, 0, 8'h12, 8'h34, 8'h12, 8'h34};
        vecs[1]  = '{8'h2A, 8'h34, 0, 0, 0, 0, 8'h00, 8'h34, 8'h00, 8'h34};
        vecs[2]  = '{8'h23, 8'h00, 1, 0, 0, 0, 8'h23, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{8'h00, 8'h15, 0, 1, 0, 0, 8'h00, 8'h15, 8'h23, 8'h15};
        vecs[4]  = '{8'h08, 8'h59, 0, 0, 1, 0, 8'h08, 8'h59, 8'h08, 8'h00};
        vecs[5]  = '{8'h08, 8'h00, 0, 0, 0, 1, 8'h08, 8'h00, 8'h08, 8'h59};
        vecs[6]  = '{8'h17, 8'h09, 0, 0, 1, 0, 8'h17, 8'h09, 8'h17, 8'h10};
        vecs[7]  = '{8'h06, 8'h45, 1, 0, 0, 0, 8'h06, 8'h45, 8'h07, 8'h45};
        vecs[8]  = '{8'h19, 8'h3C, 0, 1, 0, 0, 8'h19, 8'h00, 8'h18, 8'h00};
        vecs[9]  = '{8'h24, 8'h59, 0, 0, 0, 2, 8'h00, 8'h59, 8'h00, 8'h57};
        vecs[10] = '{8'h19, 8'h30, 1, 0, 0, 0, 8'h19, 8'h30, 8'h20, 8'h30};

        // Reset state, then a long idle with no spurious commit.
        repeat (3) @(negedge clk);
        checkOutput("reset_editing", bus.editing, 0);
        checkOutput("reset_hours", bus.set_hours, 8'h00);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        checkOutput("idle_hours", bus.set_hours, 8'h00);
        checkOutput("idle_minutes", bus.set_minutes, 8'h00);
        checkOutput("idle_field", bus.field_sel, 0);
        checkOutput("idle_no_load", load_cnt, 0);

        for (int v = 0; v < 11; v++) begin
            bus.time_hours   = vecs[v].th;
            bus.time_minutes = vecs[v].tm;
            pressN(0, 1);
            checkOutput($sformatf("v%0d_editing", v), bus.editing, 1);
            checkOutput($sformatf("v%0d_field_h", v), bus.field_sel, 1);
            checkOutput($sformatf("v%0d_cap_h", v), bus.set_hours, vecs[v].cap_h);
            checkOutput($sformatf("v%0d_cap_m", v), bus.set_minutes, vecs[v].cap_m);
            pressN(1, vecs[v].up_h);
            pressN(2, vecs[v].dn_h);
            pressN(0, 1);
            checkOutput($sformatf("v%0d_field_m", v), bus.field_sel, 2);
            checkOutput($sformatf("v%0d_hours", v), bus.set_hours, vecs[v].exp_h);
            pressN(1, vecs[v].up_m);
            pressN(2, vecs[v].dn_m);
            lc = load_cnt;
            pressN(0, 1);
            checkOutput($sformatf("v%0d_load_count", v), load_cnt - lc, 1);
            checkOutput($sformatf("v%0d_load_h", v), load_h, vecs[v].exp_h);
            checkOutput($sformatf("v%0d_load_m", v), load_m, vecs[v].exp_m);
            checkOutput($sformatf("v%0d_done_editing", v), bus.editing, 0);
            checkOutput($sformatf("v%0d_done_field", v), bus.field_sel, 0);
            checkOutput($sformatf("v%0d_hold_m", v), bus.set_minutes, vecs[v].exp_m);
        end

        // Glitch rejection and exact press latency in EDIT_H.
        bus.time_hours   = 8'h12;
        bus.time_minutes = 8'h34;
        pressN(0, 1);
        applyStimulus(1, DEB - 1);
        checkOutput("glitch_hours", bus.set_hours, 8'h12);
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (DEB + 3) @(posedge clk);
        #1;
        checkOutput("latency_early", bus.set_hours, 8'h12);
        @(posedge clk);
        #1;
        checkOutput("latency_step", bus.set_hours, 8'h13);
        @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        checkOutput("release_no_event", bus.set_hours, 8'h13);
        pressN(0, 2);

        // Reset asserted mid-clock while the final mode press is in flight.
        bus.time_hours   = 8'h06;
        bus.time_minutes = 8'h45;
        pressN(0, 1);
        pressN(1, 1);
        pressN(0, 1);
        checkOutput("abort_pre_hours", bus.set_hours, 8'h07);
        lc = load_cnt;
        @(negedge clk);
        bus.btn_mode = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_editing", bus.editing, 0);
        checkOutput("abort_field", bus.field_sel, 0);
        checkOutput("abort_hours", bus.set_hours, 8'h00);
        checkOutput("abort_minutes", bus.set_minutes, 8'h00);
        bus.btn_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("abort_no_load", load_cnt - lc, 0);
        checkOutput("abort_idle_hours", bus.set_hours, 8'h00);

        // Long hold of up in EDIT_M: one press event plus repeats when enabled.
        bus.time_hours   = 8'h10;
        bus.time_minutes = 8'h10;
        pressN(0, 2);
        applyStimulus(1, 40);
`ifdef TIME_SET_AUTO_REPEAT_EN
        exp_rep = 8'h15;
`else
        exp_rep = 8'h11;
`endif
        checkOutput("hold_minutes", bus.set_minutes, exp_rep);
        pressN(0, 1);
        checkOutput("hold_commit_m", load_m, exp_rep);

        // Randomized presses against a decimal model of the editor.
        doReset();
        mstate    = 0;
        mh        = 0;
        mm        = 0;
        exp_loads = load_cnt;
        for (int it = 0; it < 60; it++) begin
            int which, hold;
            if (mstate == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.time_hours   = 8'($urandom_range(0, 255));
                    bus.time_minutes = 8'($urandom_range(0, 255));
                end else begin
                    bus.time_hours   = to_bcd($urandom_range(0, 23));
                    bus.time_minutes = to_bcd($urandom_range(0, 59));
                end
            end
            which = $urandom_range(0, 2);
            hold  = $urandom_range(1, 12);
            applyStimulus(which, hold);
            if (hold >= DEB) begin
                case (mstate)
                    0: if (which == 0) begin
                        mh     = decode(bus.time_hours, 23);
                        mm     = decode(bus.time_minutes, 59);
                        mstate = 1;
                    end
                    1: begin
                        if (which == 0)      mstate = 2;
                        else if (which == 1) mh = (mh + 1) % 24;
                        else                 mh = (mh + 23) % 24;
                    end
                    default: begin
                        if (which == 0) begin
                            mstate = 0;
                            exp_loads++;
                        end
                        else if (which == 1) mm = (mm + 1) % 60;
                        else                 mm = (mm + 59) % 60;
                    end
                endcase
            end
            checkOutput($sformatf("rnd%0d_hours", it), bus.set_hours, to_bcd(mh));
            checkOutput($sformatf("rnd%0d_minutes", it), bus.set_minutes, to_bcd(mm));
            checkOutput($sformatf("rnd%0d_field", it), bus.field_sel, mstate);
            checkOutput($sformatf("rnd%0d_loads", it), load_cnt, exp_loads);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
